// File: rtl/ledpwm_multi.sv
// ledpwm_multi: multi-channel LED PWM controller.
// One shared prescaler and sawtooth ramp drive every channel. Each channel
// compares its level (off / static / breathe / blink) against the ramp.
// Configuration lands in shadow registers and is committed to the active
// registers only on the last cycle of a PWM period, so outputs never glitch.
module ledpwm_multi #(
  parameter int NCH           = 4,
  parameter int PWM_W         = 8,
  parameter int PRESCALE      = 250,
  parameter int BLINK_PERIODS = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PWM_W-1:0] cfg_duty,
  output logic [NCH-1:0]   led,
  output logic             period_end
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BLINK_PERIODS - 1);
  localparam logic [4:0]       NCH_L     = 5'(NCH);
  localparam logic [PWM_W:0]   BRE_STEP  = {{PWM_W{1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] RAMP_LAST = {PWM_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // shared timebase
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [PWM_W-1:0] ramp_q, ramp_d;
  logic             pend_q, pend_d;
  logic             tick_s;
  logic             pend_s;
  logic             wr_ok_s;

  // per-channel configuration and animation state
  mode_e            shadow_mode_q [NCH];
  mode_e            shadow_mode_d [NCH];
  logic [PWM_W-1:0] shadow_duty_q [NCH];
  logic [PWM_W-1:0] shadow_duty_d [NCH];
  mode_e            act_mode_q    [NCH];
  mode_e            act_mode_d    [NCH];
  logic [PWM_W-1:0] act_duty_q    [NCH];
  logic [PWM_W-1:0] act_duty_d    [NCH];
  logic [PWM_W-1:0] bre_q         [NCH];
  logic [PWM_W-1:0] bre_d         [NCH];
  logic             dir_down_q    [NCH];  // 0 = rising, 1 = falling
  logic             dir_down_d    [NCH];
  logic [BC_W-1:0]  bcnt_q        [NCH];
  logic [BC_W-1:0]  bcnt_d        [NCH];
  logic             phase_off_q   [NCH];  // 0 = blink ON phase, 1 = OFF phase
  logic             phase_off_d   [NCH];
  logic [PWM_W-1:0] level_s       [NCH];
  logic [NCH-1:0]   led_q, led_d;

  assign tick_s  = (pcnt_q == PC_LAST);
  assign pend_s  = tick_s && (ramp_q == RAMP_LAST);
  assign wr_ok_s = cfg_we && ({1'b0, cfg_ch} < NCH_L);

  // Prescaler, ramp, and a registered period_end that lines up with pend_s.
  always_comb begin
    if (tick_s) begin
      pcnt_d = {PC_W{1'b0}};
      ramp_d = ramp_q + {{(PWM_W-1){1'b0}}, 1'b1};
    end else begin
      pcnt_d = pcnt_q + {{(PC_W-1){1'b0}}, 1'b1};
      ramp_d = ramp_q;
    end
    pend_d = (pcnt_d == PC_LAST) && (ramp_d == RAMP_LAST);
  end

  // Shadow writes, period-boundary commit and breathe/blink stepping.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shadow_mode_d[i] = shadow_mode_q[i];
      shadow_duty_d[i] = shadow_duty_q[i];
      act_mode_d[i]    = act_mode_q[i];
      act_duty_d[i]    = act_duty_q[i];
      bre_d[i]         = bre_q[i];
      dir_down_d[i]    = dir_down_q[i];
      bcnt_d[i]        = bcnt_q[i];
      phase_off_d[i]   = phase_off_q[i];

      if (wr_ok_s && (cfg_ch == 4'(i))) begin
        shadow_mode_d[i] = mode_e'(cfg_mode);
        shadow_duty_d[i] = cfg_duty;
      end else begin
        shadow_mode_d[i] = shadow_mode_q[i];
        shadow_duty_d[i] = shadow_duty_q[i];
      end

      // The commit reads shadow_*_q, so a write in this same cycle waits a period.
      if (pend_s) begin
        act_mode_d[i] = shadow_mode_q[i];
        act_duty_d[i] = shadow_duty_q[i];
        if (shadow_mode_q[i] != act_mode_q[i]) begin
          bre_d[i]       = {PWM_W{1'b0}};
          dir_down_d[i]  = 1'b0;
          bcnt_d[i]      = {BC_W{1'b0}};
          phase_off_d[i] = 1'b0;
        end else begin
          case (shadow_mode_q[i])
            MODE_BREATHE: begin
              if (!dir_down_q[i]) begin
                if (({1'b0, bre_q[i]} + BRE_STEP) >= {1'b0, shadow_duty_q[i]}) begin
                  bre_d[i]      = shadow_duty_q[i];
                  dir_down_d[i] = 1'b1;
                end else begin
                  bre_d[i]      = bre_q[i] + {{(PWM_W-1){1'b0}}, 1'b1};
                  dir_down_d[i] = 1'b0;
                end
              end else begin
                if (bre_q[i] > shadow_duty_q[i]) begin
                  bre_d[i]      = shadow_duty_q[i];
                  dir_down_d[i] = 1'b1;
                end else if (bre_q[i] <= {{(PWM_W-1){1'b0}}, 1'b1}) begin
                  bre_d[i]      = {PWM_W{1'b0}};
                  dir_down_d[i] = 1'b0;
                end else begin
                  bre_d[i]      = bre_q[i] - {{(PWM_W-1){1'b0}}, 1'b1};
                  dir_down_d[i] = 1'b1;
                end
              end
            end
            MODE_BLINK: begin
              if (bcnt_q[i] == BC_LAST) begin
                bcnt_d[i]      = {BC_W{1'b0}};
                phase_off_d[i] = !phase_off_q[i];
              end else begin
                bcnt_d[i]      = bcnt_q[i] + {{(BC_W-1){1'b0}}, 1'b1};
                phase_off_d[i] = phase_off_q[i];
              end
            end
            default: begin
              bre_d[i]  = bre_q[i];
              bcnt_d[i] = bcnt_q[i];
            end
          endcase
        end
      end else begin
        act_mode_d[i] = act_mode_q[i];
        act_duty_d[i] = act_duty_q[i];
      end
    end
  end

  // Per-channel level selection and comparison against the ramp.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      case (act_mode_q[i])
        MODE_OFF:     level_s[i] = {PWM_W{1'b0}};
        MODE_STATIC:  level_s[i] = act_duty_q[i];
        MODE_BREATHE: level_s[i] = bre_q[i];
        MODE_BLINK:   level_s[i] = phase_off_q[i] ? {PWM_W{1'b0}} : act_duty_q[i];
        default:      level_s[i] = {PWM_W{1'b0}};
      endcase
      led_d[i] = (level_s[i] > ramp_q);
    end
  end

  // State registers; arst clears everything so all channels come up OFF.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pcnt_q        <= {PC_W{1'b0}};
      ramp_q        <= {PWM_W{1'b0}};
      pend_q        <= 1'b0;
      led_q         <= {NCH{1'b0}};
      shadow_mode_q <= '{default: MODE_OFF};
      shadow_duty_q <= '{default: {PWM_W{1'b0}}};
      act_mode_q    <= '{default: MODE_OFF};
      act_duty_q    <= '{default: {PWM_W{1'b0}}};
      bre_q         <= '{default: {PWM_W{1'b0}}};
      dir_down_q    <= '{default: 1'b0};
      bcnt_q        <= '{default: {BC_W{1'b0}}};
      phase_off_q   <= '{default: 1'b0};
    end else begin
      pcnt_q        <= pcnt_d;
      ramp_q        <= ramp_d;
      pend_q        <= pend_d;
      led_q         <= led_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_duty_q <= shadow_duty_d;
      act_mode_q    <= act_mode_d;
      act_duty_q    <= act_duty_d;
      bre_q         <= bre_d;
      dir_down_q    <= dir_down_d;
      bcnt_q        <= bcnt_d;
      phase_off_q   <= phase_off_d;
    end
  end

  assign led        = led_q;
  assign period_end = pend_q;

endmodule

// File: tb/tb_ledpwm_multi.sv
// Scoreboard bench for ledpwm_multi. The driver issues directed and random
// configuration writes, runs a period-level reference model, and queues the
// expected level of every channel for each upcoming PWM period. The monitor
// captures each period's led waveform and period_end position and compares.
module tb_ledpwm_multi;

  localparam int NCH           = 2;
  localparam int PWM_W         = 4;
  localparam int PRESCALE      = 4;
  localparam int BLINK_PERIODS = 2;
  localparam int PER           = PRESCALE * (1 << PWM_W);

  logic             clk      = 1'b0;
  logic             arst     = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [3:0]       cfg_ch   = 4'd0;
  logic [1:0]       cfg_mode = 2'd0;
  logic [PWM_W-1:0] cfg_duty = '0;
  logic [NCH-1:0]   led;
  logic             period_end;

  ledpwm_multi #(
    .NCH(NCH), .PWM_W(PWM_W), .PRESCALE(PRESCALE), .BLINK_PERIODS(BLINK_PERIODS)
  ) dut (
    .clk(clk), .arst(arst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led(led), .period_end(period_end)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  typedef logic [NCH-1:0][7:0] lvl_t;
  lvl_t exp_q[$];

  // reference model: per-channel shadow/active config plus animation position
  int m_smode [NCH];
  int m_sduty [NCH];
  int m_amode [NCH];
  int m_aduty [NCH];
  int m_bre   [NCH];
  int m_up    [NCH];
  int m_np    [NCH];   // periods elapsed since the mode last changed
  int drv_cyc = 0;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_smode[c] = 0; m_sduty[c] = 0; m_amode[c] = 0; m_aduty[c] = 0;
      m_bre[c] = 0; m_up[c] = 1; m_np[c] = 0;
    end
  endfunction

  function automatic int model_level(int c);
    case (m_amode[c])
      1: return m_aduty[c];
      2: return m_bre[c];
      3: return (((m_np[c] / BLINK_PERIODS) % 2) == 0) ? m_aduty[c] : 0;
      default: return 0;
    endcase
  endfunction

  function automatic lvl_t model_levels();
    lvl_t lv;
    for (int c = 0; c < NCH; c++) lv[c] = 8'(model_level(c));
    return lv;
  endfunction

  function automatic void model_commit();
    for (int c = 0; c < NCH; c++) begin
      int d;
      d = m_sduty[c];
      if (m_smode[c] != m_amode[c]) begin
        m_bre[c] = 0; m_up[c] = 1; m_np[c] = 0;
      end else begin
        m_np[c] = m_np[c] + 1;
        if (m_smode[c] == 2) begin
          if (m_up[c] != 0) begin
            if (m_bre[c] + 1 >= d) begin m_bre[c] = d; m_up[c] = 0; end
            else m_bre[c] = m_bre[c] + 1;
          end else begin
            if (m_bre[c] > d) m_bre[c] = d;
            else if (m_bre[c] <= 1) begin m_bre[c] = 0; m_up[c] = 1; end
            else m_bre[c] = m_bre[c] - 1;
          end
        end
      end
      m_amode[c] = m_smode[c];
      m_aduty[c] = d;
    end
  endfunction

  // one clock cycle of stimulus; the write is captured at the next posedge
  task automatic cycle(input bit we, input int ch, input int mode, input int duty);
    @(negedge clk);
    cfg_we   = we;
    cfg_ch   = 4'(ch);
    cfg_mode = 2'(mode);
    cfg_duty = PWM_W'(duty);
    if ((drv_cyc % PER) == PER - 1) begin
      model_commit();
      exp_q.push_back(model_levels());
    end
    if (we && ch < NCH) begin
      m_smode[ch] = mode;
      m_sduty[ch] = duty;
    end
    drv_cyc++;
  endtask

  task automatic idle_until(input int c);
    while (drv_cyc < c) cycle(1'b0, 0, 0, 0);
  endtask

  task automatic write_at(input int c, input int ch, input int mode, input int duty);
    idle_until(c);
    cycle(1'b1, ch, mode, duty);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    cfg_we = 1'b0;
    #3;
    arst = 1'b1;
    #1;
    n_tests++;
    if (led !== '0) begin
      n_fail++;
      $display("FAIL led_on_reset_assert: got %b, required %b", led, {NCH{1'b0}});
    end
    model_reset();
    exp_q.delete();
    repeat (hold) @(posedge clk);
    #2;
    arst = 1'b0;
    drv_cyc = 0;
    started = 1'b1;
    exp_q.push_back(model_levels());
  endtask

  // monitor: one window per PWM period, checked against the queued levels
  initial begin
    int off;
    int win;
    bit pe_bad;
    logic [PER-1:0] cap [NCH];
    logic [PER-1:0] ev;
    lvl_t e;
    off = 0; win = 0; pe_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (arst) begin
        n_tests++;
        if (led !== '0 || period_end !== 1'b0) begin
          n_fail++;
          $display("FAIL outputs_in_reset: got led=%b period_end=%b, required 0/0", led, period_end);
        end
        off = 0;
        pe_bad = 1'b0;
      end else if (started) begin
        for (int c = 0; c < NCH; c++) cap[c][off] = led[c];
        if (period_end !== ((off == PER - 1) ? 1'b1 : 1'b0)) pe_bad = 1'b1;
        if (off == PER - 1) begin
          n_tests++;
          if (pe_bad) begin
            n_fail++;
            $display("FAIL period_end_timing window %0d: got misplaced pulse, required only at offset %0d", win, PER - 1);
          end
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty window %0d: got no expectation, required one", win);
          end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < NCH; c++) begin
              // led lags the ramp by one cycle; offset j shows ramp step (j-1)/PRESCALE
              for (int j = 0; j < PER; j++)
                ev[j] = (j >= 1) && (int'(e[c]) > ((j - 1) / PRESCALE));
              n_tests++;
              if (cap[c] !== ev) begin
                n_fail++;
                $display("FAIL led_ch%0d window %0d: got %h, required %h (level %0d)", c, win, cap[c], ev, e[c]);
              end
            end
          end
          win++;
          off = 0;
          pe_bad = 1'b0;
        end else begin
          off++;
        end
      end
    end
  end

  // driver: directed scenarios, then random traffic
  initial begin
    do_reset(3);
    write_at(10, 0, 1, 5);                      // static duty 5
    idle_until(3 * PER);
    write_at(3 * PER + 20, 0, 1, 10);           // mid-period update
    write_at(4 * PER + PER - 1, 0, 1, 3);       // write in period_end cycle
    idle_until(7 * PER);
    write_at(7 * PER + 5, 1, 2, 3);             // breathe peak 3
    idle_until(17 * PER);
    write_at(17 * PER + 30, 0, 3, 15);          // blink on-level 15
    idle_until(25 * PER);
    write_at(25 * PER + 3, 3, 1, 15);           // out-of-range channels
    write_at(25 * PER + 4, 2, 2, 9);
    idle_until(27 * PER);
    write_at(27 * PER + 8, 1, 2, 7);            // raise breathe peak
    idle_until(31 * PER + 30);
    do_reset(3);                                // reset mid-breathe
    idle_until(3 * PER);
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < PER; k++) begin
        if ($urandom_range(0, 15) == 0 || ((drv_cyc % PER) == PER - 1 && $urandom_range(0, 2) == 0))
          cycle(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        else
          cycle(1'b0, 0, 0, 0);
      end
    end
    idle_until(((drv_cyc / PER) + 1) * PER + 2);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // run-time guard
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: got no completion, required finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
